voice_flap_trigger: RTL



---
 rtl/voice_flap_trigger.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/voice_flap_trigger.sv
// Turns a stream of audio samples into a level-sensitive flap enable.
// The mean absolute amplitude of each fixed-length window sets a loud flag
// with hysteresis. A loud window while armed starts a flap that lasts a fixed
// number of game ticks. A cooldown follows, and the trigger re-arms only
// after the input has gone quiet again.
module voice_flap_trigger #(
  parameter int                   SAMPLE_W   = 24,
  parameter int                   WIN_LOG2   = 8,
  parameter logic [SAMPLE_W-1:0]  THRESH_ON  = 24'd40000,
  parameter logic [SAMPLE_W-1:0]  THRESH_OFF = 24'd20000,
  parameter int                   HOLD_TICKS = 8,
  parameter int                   COOL_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                tick,
  output logic                cycle,
  output logic [7:0]          level,
  output logic                win_done,
  output logic                armed
);

  localparam int                  ACC_W    = SAMPLE_W + WIN_LOG2;
  localparam logic [SAMPLE_W-1:0] S_MIN    = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAG_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

  typedef enum logic [1:0] {QUIET, FLAP, COOLDOWN} state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic                loud_q, loud_d;
  logic [7:0]          level_q, level_d;
  logic                win_done_q, win_done_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic [7:0]          cool_cnt_q, cool_cnt_d;

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    acc_sum;
  logic [SAMPLE_W-1:0] mean;

  // Absolute value of the sample; the most negative code has no positive twin, so it saturates.
  always_comb begin
    if (sample_data == S_MIN) begin
      mag = MAG_MAX;
    end else if (sample_data[SAMPLE_W-1]) begin
      mag = -sample_data;
    end else begin
      mag = sample_data;
    end
  end

  assign acc_sum = acc_q + ACC_W'(mag);
  assign mean    = acc_sum[ACC_W-1:WIN_LOG2];

  // Window accumulation, level capture and the hysteretic loud flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    acc_d      = acc_q;
    win_cnt_d  = win_cnt_q;
    loud_d     = loud_q;
    level_d    = level_q;
    win_done_d = 1'b0;
    if (sample_valid) begin
      win_cnt_d = win_cnt_q + 1'b1;
      if (win_cnt_q == WIN_LAST) begin
        acc_d      = '0;
        level_d    = mean[SAMPLE_W-2 -: 8];
        win_done_d = 1'b1;
        if (mean >= THRESH_ON) begin
          loud_d = 1'b1;
        end else if (mean < THRESH_OFF) begin
          loud_d = 1'b0;
        end
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Flap sequencing. It acts on the registered window result, one clock after the window closes.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cool_cnt_d = cool_cnt_q;
    unique case (state_q)
      QUIET: begin
        if (win_done_q && loud_q) begin
          state_d    = FLAP;
          hold_cnt_d = 8'(HOLD_TICKS);
        end
      end
      FLAP: begin
        if (tick) begin
          if (hold_cnt_q == 8'd1) begin
            state_d    = COOLDOWN;
            cool_cnt_d = 8'(COOL_TICKS);
          end else begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end
        end
      end
      COOLDOWN: begin
        if (cool_cnt_q == 8'd0) begin
          if (!loud_q) begin
            state_d = QUIET;
          end
        end else if (tick) begin
          cool_cnt_d = cool_cnt_q - 8'd1;
        end
      end
      default: state_d = QUIET;
    endcase
  end

  // State registers with synchronous reset; reset discards any partial window.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q    <= QUIET;
      acc_q      <= '0;
      win_cnt_q  <= '0;
      loud_q     <= 1'b0;
      level_q    <= 8'd0;
      win_done_q <= 1'b0;
      hold_cnt_q <= 8'd0;
      cool_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      win_cnt_q  <= win_cnt_d;
      loud_q     <= loud_d;
      level_q    <= level_d;
      win_done_q <= win_done_d;
      hold_cnt_q <= hold_cnt_d;
      cool_cnt_q <= cool_cnt_d;
    end
  end

  assign cycle    = (state_q == FLAP);
  assign armed    = (state_q == QUIET);
  assign level    = level_q;
  assign win_done = win_done_q;

endmodule
